// File: rtl/bcd_chain_counter.sv
// Cascaded modulo-(bound+1) digit counter with up/down, load, clear and optional saturation.
// Each digit is one bcd_chain_stage; the top resolves the ripple-enable chain and the chain carry.

module bcd_chain_stage #(
  parameter int bound = 9,
  parameter int width = $clog2(bound + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [width-1:0] load_val,
  input  logic             step,
  input  logic             up,
  input  logic             hold,
  output logic [width-1:0] q,
  output logic             term
);
  localparam logic [width-1:0] BND = width'(bound);

  logic [width-1:0] nxt;
  logic [width-1:0] ld_clamped;

  assign term       = up ? (q == BND) : (q == '0);
  assign nxt        = up ? ((q == BND) ? '0 : q + width'(1))
                         : ((q == '0) ? BND : q - width'(1));
  // Out-of-range load fields clamp so a digit can never exceed bound.
  assign ld_clamped = (load_val > BND) ? BND : load_val;

  always_ff @(posedge clk) begin
    if (reset)              q <= '0;
    else if (clear)         q <= '0;
    else if (load)          q <= ld_clamped;
    else if (step && !hold) q <= nxt;
  end
endmodule

module bcd_chain_counter #(
  parameter int bound    = 9,
  parameter int stages   = 4,
  parameter int width    = $clog2(bound + 1),
  parameter bit saturate = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [stages*width-1:0] load_val,
  output logic [stages*width-1:0] num,
  output logic                    carry,
  output logic                    wrapped
);
  logic [stages-1:0][width-1:0] q;
  logic [stages-1:0]            term;
  logic [stages-1:0]            step;
  logic                         hold;

  // Stage i steps only when every lower stage sits at its terminal value.
  always_comb begin
    logic run;
    step = '0;
    run  = ena;
    for (int i = 0; i < stages; i++) begin
      step[i] = run;
      run     = run & term[i];
    end
  end

  assign carry = ena && !clear && !load && (&term);
  assign hold  = saturate && carry;
  assign num   = q;

  for (genvar i = 0; i < stages; i++) begin : g_stage
    bcd_chain_stage #(.bound(bound), .width(width)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .load     (load),
      .load_val (load_val[i*width +: width]),
      .step     (step[i]),
      .up       (up),
      .hold     (hold),
      .q        (q[i]),
      .term     (term[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)      wrapped <= 1'b0;
    else if (clear) wrapped <= 1'b0;
    else if (carry) wrapped <= 1'b1;
  end
endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed bench: a wrapping and a saturating 2-digit decimal counter share one stimulus stream.
module tb_bcd_chain_counter;
  logic       clk = 1'b0;
  logic       reset, ena, up, clear, load;
  logic [7:0] load_val;
  logic [7:0] num_w, num_s;
  logic       carry_w, carry_s, wrapped_w, wrapped_s;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  bcd_chain_counter #(.bound(9), .stages(2), .width(4), .saturate(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .ena(ena), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .num(num_w), .carry(carry_w), .wrapped(wrapped_w));

  bcd_chain_counter #(.bound(9), .stages(2), .width(4), .saturate(1'b1)) u_sat (
    .clk(clk), .reset(reset), .ena(ena), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .num(num_s), .carry(carry_s), .wrapped(wrapped_s));

  typedef struct {
    logic       rst, clr, ld, en, u;
    logic [7:0] lv;
    logic [7:0] exp_nw;
    logic       exp_cw;
    logic [7:0] exp_ns;
    logic       exp_cs;
    logic       exp_wr;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic e,
                       input logic u, input logic [7:0] v);
    @(negedge clk);
    reset = r; clear = c; load = l; ena = e; up = u; load_val = v;
    #1;
  endtask

  function automatic logic [7:0] bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  initial begin
    reset = 1'b1; ena = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;

    //            rst clr ld en u  lv     nw     cw  ns     cs  wr
    vecs[0]  = '{1, 0, 1, 1, 1, 8'h55, 8'h00, 0, 8'h00, 0, 0};
    vecs[1]  = '{1, 0, 1, 1, 1, 8'h55, 8'h00, 0, 8'h00, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 1, 8'h00, 8'h01, 0, 8'h01, 0, 0};
    vecs[3]  = '{0, 0, 1, 1, 1, 8'hC3, 8'h93, 0, 8'h93, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 8'h00, 8'h94, 0, 8'h94, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 1, 8'h98, 8'h98, 0, 8'h98, 0, 0};
    vecs[6]  = '{0, 0, 0, 1, 1, 8'h00, 8'h99, 0, 8'h99, 0, 0};
    vecs[7]  = '{0, 0, 0, 1, 1, 8'h00, 8'h00, 1, 8'h99, 1, 1};
    vecs[8]  = '{0, 0, 0, 1, 0, 8'h00, 8'h99, 1, 8'h98, 0, 1};
    vecs[9]  = '{0, 0, 0, 1, 0, 8'h00, 8'h98, 0, 8'h97, 0, 1};
    vecs[10] = '{0, 1, 1, 0, 1, 8'h55, 8'h00, 0, 8'h00, 0, 0};
    vecs[11] = '{0, 0, 1, 0, 1, 8'h39, 8'h39, 0, 8'h39, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 1, 8'h00, 8'h40, 0, 8'h40, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 0, 8'h00, 8'h39, 0, 8'h39, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 1, 8'h00, 8'h40, 0, 8'h40, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 0, 8'h00, 8'h39, 0, 8'h39, 0, 0};
    vecs[16] = '{0, 0, 0, 1, 1, 8'h00, 8'h40, 0, 8'h40, 0, 0};
    vecs[17] = '{1, 0, 1, 1, 1, 8'h77, 8'h00, 0, 8'h00, 0, 0};
    vecs[18] = '{0, 0, 0, 1, 1, 8'h00, 8'h01, 0, 8'h01, 0, 0};
    vecs[19] = '{0, 1, 0, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 0};
    vecs[20] = '{1, 0, 0, 1, 0, 8'h00, 8'h00, 1, 8'h00, 1, 0};
    vecs[21] = '{0, 0, 0, 1, 0, 8'h00, 8'h99, 1, 8'h00, 1, 1};
    vecs[22] = '{0, 0, 1, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 1};

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].ld, vecs[i].en, vecs[i].u, vecs[i].lv);
      chk($sformatf("v%0d carry_w", i), 32'(carry_w), 32'(vecs[i].exp_cw));
      chk($sformatf("v%0d carry_s", i), 32'(carry_s), 32'(vecs[i].exp_cs));
      @(posedge clk); #1;
      chk($sformatf("v%0d num_w", i), 32'(num_w), 32'(vecs[i].exp_nw));
      chk($sformatf("v%0d num_s", i), 32'(num_s), 32'(vecs[i].exp_ns));
      chk($sformatf("v%0d wrapped_w", i), 32'(wrapped_w), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d wrapped_s", i), 32'(wrapped_s), 32'(vecs[i].exp_wr));
    end

    // Full up period from 00: carry only at 99, wrap back to 00.
    drive(0, 1, 0, 0, 1, 8'h00);
    @(posedge clk); #1;
    chk("pre_run num_w", 32'(num_w), 32'h0);
    for (int c = 0; c < 100; c++) begin
      drive(0, 0, 0, 1, 1, 8'h00);
      chk($sformatf("run%0d carry_w", c), 32'(carry_w), 32'(c == 99));
      chk($sformatf("run%0d carry_s", c), 32'(carry_s), 32'(c == 99));
      @(posedge clk); #1;
      chk($sformatf("run%0d num_w", c), 32'(num_w), 32'(bcd((c + 1) % 100)));
      chk($sformatf("run%0d num_s", c), 32'(num_s), 32'(bcd(c == 99 ? 99 : c + 1)));
    end
    chk("run wrapped_w", 32'(wrapped_w), 32'h1);
    chk("run wrapped_s", 32'(wrapped_s), 32'h1);

    // Saturating counter sits at 99: holds with carry, then steps down on direction flip.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 1, 8'h00);
      chk($sformatf("sat%0d carry_s", k), 32'(carry_s), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d num_s", k), 32'(num_s), 32'h99);
      chk($sformatf("sat%0d wrapped_s", k), 32'(wrapped_s), 32'h1);
    end
    drive(0, 0, 0, 1, 0, 8'h00);
    chk("sat_down carry_s", 32'(carry_s), 32'h0);
    @(posedge clk); #1;
    chk("sat_down num_s", 32'(num_s), 32'h98);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_chain_counter.md
# bcd_chain_counter

Parametrised multi-stage modulo counter: `stages` cascaded digits, each counting 0..`bound` inclusive, with up/down direction, synchronous load, clear, and optional saturation. Generalises the single-stage wrap counter to multi-digit display and timing chains, such as seconds/minutes clocks and BCD event counters, on the FPGA side. Exposes a chain-level carry/borrow for further cascading and a sticky wrap flag for status readback.

## Interface

Parameters:
- `bound`, default 9: maximum value of every stage, inclusive; must be ≥ 1.
- `stages`, default 4: number of cascaded digits; must be ≥ 1.
- `width`, default $clog2(bound+1): bits per stage.
- `saturate`, default 0: 0 wraps at the terminal count; 1 holds at the terminal count.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high; clears all state.
- `ena`, in, 1: count enable for one step this cycle.
- `up`, in, 1: 1 counts up, 0 counts down; sampled every cycle.
- `clear`, in, 1: synchronous clear of all stages to 0.
- `load`, in, 1: synchronous parallel load.
- `load_val`, in, stages*width: load value; stage i sits at bits [i*width +: width].
- `num`, out, stages*width: registered count; stage 0 is least significant.
- `carry`, out, 1: combinational; step this cycle crosses the chain terminal count.
- `wrapped`, out, 1: registered, sticky; set when a wrap occurs, cleared by `clear` or `reset`.

## Operation

- Priority per cycle: `reset` > `clear` > `load` > `ena`.
  - `reset`: `num` = 0, `wrapped` = 0.
  - `clear`: `num` = 0, `wrapped` = 0.
  - `load`: each stage takes its `load_val` field. A field > `bound` clamps to `bound`. `wrapped` is unchanged.
- Stage terminal value: `bound` when `up`=1, 0 when `up`=0.
- Stage i steps when `ena` && every stage j < i is at its terminal value. Stage 0 steps on every `ena`.
- Step rules:
  - Up: `bound` → 0; otherwise +1.
  - Down: 0 → `bound`; otherwise −1.
  - Per-stage arithmetic is in `width` bits. Stage values never exceed `bound`.
- Chain terminal: all stages at their terminal value.
- `carry` = `ena` && !`clear` && !`load` && chain terminal. It does not depend on `reset`.
- When `carry`=1:
  - `saturate`=0: all stages wrap (up → all 0; down → all `bound`), and `wrapped` is set to 1 on the same edge.
  - `saturate`=1: `num` holds, `carry` is still asserted, and `wrapped` is set.
- A direction change takes effect in the cycle it is presented. No pipeline or history state exists.
- Stage values > `bound` are unreachable from any legal operation.

## Timing

- `num` and `wrapped` change only on the rising `clk` edge. Latency from a qualifying input to the new `num` is one edge.
- `carry` is combinational from the current `num`, `ena`, `up`, `clear`, and `load`. It is valid in the same cycle as the step that wraps.
- Reset values: `num` = 0, `wrapped` = 0. `carry` = 0 after reset unless `ena`=1 and `up`=0, because 0 is the down-terminal.
- `reset` asserted mid-count forces zero at the next edge regardless of `ena`, `load`, or `clear`. The count resumes from 0 on the first edge after release.
- With `ena` held high, `up`=1, `saturate`=0, the period is (`bound`+1)^`stages` cycles, with exactly one `carry` cycle per period.

## Test plan

- **Reset:** `reset`=1 for 2 cycles with `ena`=1, `load`=1 → `num`=0 and `wrapped`=0 after release; `carry`=0 with `up`=1.
- **Up wrap** (`bound`=9, `stages`=2): `ena`=1, `up`=1 for 100 cycles from 0 → `num` steps 00..99 in BCD order. `carry`=1 only in the cycle `num`=99. Next `num`=00, `wrapped`=1.
- **Down borrow:** from 00 with `ena`=1, `up`=0 → `carry`=1 immediately. Next `num`=99, then 98. Stage 1 steps only when stage 0 is 0.
- **Load/clear priority:**
  - `load_val`={4'hC, 4'h3} with `load`=1 → `num`={9,3}, because the field 0xC clamps to 9.
  - `load`=1 and `clear`=1 together → `num`=0 and `wrapped`=0.
  - `ena`=1 during `load` → no count step.
- **Saturate** (`saturate`=1): count up to 99 → `num` holds at 99 with `carry`=1 every enabled cycle and `wrapped`=1. Then `up`=0 → 98 on the next edge.
- **Direction flip and mid-run reset:** at `num`=39, alternate `up` each cycle with `ena`=1 → 40, 39, 40, 39. Assert `reset` at 40 → `num`=0 on the next edge.
